// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and constants for the 16-bit RISC pipeline
package risc_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 3;

  localparam logic [WORD_W-1:0] BUS_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/mem_access_stage_timeout.sv
// rtl/mem_access_stage_timeout.sv - bus_timeout_counter: counts BUSY cycles, flags the last allowed one
module bus_timeout_counter #(
  parameter int TIMEOUT = 16,
  localparam int CNT_W  = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // count holds the number of completed BUSY cycles, so TIMEOUT-1 marks the TIMEOUT-th one
  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage bus master with stall and write-back bubble injection
module mem_access_stage
  import risc_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WORD_W-1:0]     alu_result_in,
  input  logic [WORD_W-1:0]     write_data_in,
  input  logic [REG_ADDR_W-1:0] mux_rd_rt_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  input  logic                  MemToReg_in,
  input  logic                  RegWrite_in,
  output logic                  stall,
  output logic [WORD_W-1:0]     read_data_mem_out,
  output logic [WORD_W-1:0]     alu_result_out,
  output logic [REG_ADDR_W-1:0] mux_rd_rt_out,
  output logic                  MemToReg_out,
  output logic                  RegWrite_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [WORD_W-1:0]     mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [WORD_W-1:0]     mem_rdata,
  output logic                  bus_err
);

  mem_state_t            state;
  logic [WORD_W-1:0]     alu_q;
  logic [WORD_W-1:0]     rdata_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  memtoreg_q;
  logic                  regwrite_q;
  logic                  is_load_q;
  logic                  expired;
  logic                  mem_op;

  assign mem_op = MemRead_in | MemWrite_in;

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state != BUSY),
    .enable  (state == BUSY),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_q    <= '0;
      bus_err    <= 1'b0;
      alu_q      <= '0;
      rd_q       <= '0;
      memtoreg_q <= 1'b0;
      regwrite_q <= 1'b0;
      is_load_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            state      <= BUSY;
            mem_req    <= 1'b1;
            mem_we     <= MemWrite_in;
            mem_addr   <= alu_result_in;
            mem_wdata  <= write_data_in;
            alu_q      <= alu_result_in;
            rd_q       <= mux_rd_rt_in;
            memtoreg_q <= MemToReg_in;
            regwrite_q <= RegWrite_in;
            // read+write together behaves as a store
            is_load_q  <= MemRead_in & ~MemWrite_in;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata_q <= is_load_q ? mem_rdata : '0;
            mem_req <= 1'b0;
            state   <= DONE;
          end else if (expired) begin
            rdata_q <= BUS_ERR_DATA;
            bus_err <= 1'b1;
            mem_req <= 1'b0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall             = 1'b0;
    read_data_mem_out = '0;
    alu_result_out    = alu_result_in;
    mux_rd_rt_out     = mux_rd_rt_in;
    MemToReg_out      = MemToReg_in;
    RegWrite_out      = RegWrite_in;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall        = 1'b1;
          MemToReg_out = 1'b0;
          RegWrite_out = 1'b0;
        end
      end
      BUSY: begin
        stall          = 1'b1;
        alu_result_out = alu_q;
        mux_rd_rt_out  = rd_q;
        MemToReg_out   = 1'b0;
        RegWrite_out   = 1'b0;
      end
      DONE: begin
        read_data_mem_out = rdata_q;
        alu_result_out    = alu_q;
        mux_rd_rt_out     = rd_q;
        MemToReg_out      = memtoreg_q;
        RegWrite_out      = regwrite_q;
      end
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage bus master of the 16-bit RISC pipeline, between the EX/MEM register and `mem_wb_register`. It turns load/store control from EX/MEM into a req/ack transaction on a variable-latency data-memory bus and stalls the front of the pipeline until the access completes. It feeds `mem_wb_register` the loaded word plus pass-through ALU/destination/control fields. Because `mem_wb_register` has no enable, the stage injects write-back bubbles while stalled.

## Interface
- `TIMEOUT`, 16: BUSY cycles without `mem_ack` before the access is abandoned (≥2).
- `clk` in 1: single clock; all state on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `alu_result_in` in 16: ALU result; memory word address for loads/stores.
- `write_data_in` in 16: store data.
- `mux_rd_rt_in` in 3: destination register.
- `MemRead_in`, `MemWrite_in`, `MemToReg_in`, `RegWrite_in` in 1 each: control from EX/MEM.
- `stall` out 1: freeze PC, IF/ID, ID/EX, EX/MEM (combinational).
- `read_data_mem_out` out 16, `alu_result_out` out 16, `mux_rd_rt_out` out 3, `MemToReg_out` out 1, `RegWrite_out` out 1: to `mem_wb_register`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_wdata` out 16: bus request (registered).
- `mem_ack` in 1, `mem_rdata` in 16: bus completion; `mem_rdata` valid when `mem_ack`=1.
- `bus_err` out 1: sticky, set on timeout (registered).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, no mem op (`MemRead_in`=`MemWrite_in`=0):
  - `stall`=0.
  - Outputs pass inputs through combinationally; `read_data_mem_out`=0.
- IDLE, mem op:
  - `stall`=1; `RegWrite_out`=`MemToReg_out`=0 (bubble).
  - Latch the command and go to BUSY.
  - `mem_req`=1, `mem_we`=`MemWrite_in`, `mem_addr`=`alu_result_in`, `mem_wdata`=`write_data_in`, registered at the same edge.
- BUSY:
  - `stall`=1, bubble outputs; bus outputs held stable.
  - Timeout counter increments each cycle.
  - `mem_ack`=1: capture `mem_rdata` into `rdata_q` (reads only; writes capture 0), drop `mem_req`, go to DONE.
  - `TIMEOUT`-th BUSY cycle without ack: `rdata_q`=16'hFFFF, set `bus_err`, drop `mem_req`, go to DONE.
  - Ack on the TIMEOUT-th cycle wins; no error.
- DONE:
  - `stall`=0.
  - Outputs come from the latched command; `read_data_mem_out`=`rdata_q`.
  - Always returns to IDLE; no re-issue, even though upstream still shows the same instruction this cycle.
- `MemRead_in`=`MemWrite_in`=1: treated as a store; `read_data_mem_out`=0 in DONE.
- `mem_ack` outside BUSY is ignored.
- `bus_err` clears only on reset.

## Timing
- Reset (edge with `rst_n`=0):
  - State IDLE, counter 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata_q`=0, `bus_err`=0.
  - Combinational outputs then follow IDLE rules.
- Reset mid-BUSY aborts the access: `mem_req` is 0 after that edge; a late ack is ignored.
- Non-mem instruction: 0-cycle latency, no stall.
- Mem op presented in cycle 0 (IDLE):
  - `mem_req` high from cycle 1.
  - Ack sampled in BUSY cycle n (n≥1) → DONE in cycle n+1.
  - `stall` high in cycles 0..n.
  - Minimum 2 stall cycles; `mem_wb_register` captures the result at the end of cycle n+1.
- Timeout: DONE in cycle `TIMEOUT`+1; `bus_err` high from that cycle.
- Back-to-back loads: the second starts in the IDLE cycle after DONE; `mem_req` is low for at least 2 cycles between requests.

## Structure
- Shared package `risc_pkg`:
  - `mem_state_t` enum {IDLE, BUSY, DONE}.
  - `WORD_W`=16, `REG_ADDR_W`=3.
  - `BUS_ERR_DATA`=16'hFFFF.
- Counter width `$clog2(TIMEOUT+1)`.
- One sub-module is natural: `bus_timeout_counter` (clear/enable/expired).
- FSM and output muxing stay in `mem_access_stage`.

## Test plan
- ADD, `alu_result_in`=16'h1234, rd=3, RegWrite=1 → same-cycle pass-through, `stall`=0, `read_data_mem_out`=0.
- LW from 16'h0040, ack 1 cycle after `mem_req` with `mem_rdata`=16'hBEEF:
  - Expect `stall` for 2 cycles with `RegWrite_out`=0.
  - Then DONE with `read_data_mem_out`=16'hBEEF, `MemToReg_out`=1, `RegWrite_out`=1.
- SW 16'hA5A5 to 16'h0010, ack after 5 cycles → `mem_we`=1, addr/data stable all 5 cycles, `stall` for 6 cycles, `RegWrite_out`=0.
- LW, no ack (`TIMEOUT`=16):
  - `mem_req` high for exactly 16 cycles.
  - DONE returns 16'hFFFF; `bus_err`=1 and stays 1.
  - Repeat with ack on the 16th cycle → data returned, `bus_err` stays 0.
- `rst_n`=0 during BUSY cycle 3:
  - `mem_req`=0 and state IDLE after the edge.
  - A stale ack the next cycle is ignored; the next LW completes normally.
- Back-to-back LWs → exactly two request phases, 2-cycle `mem_req` gap, both values delivered in order.
